// File: rtl/cpu_lsu.sv
// Load/store unit between the EX stage and a variable-latency data memory.
// Handles byte/half/word/double lanes, load extension, misalignment and wait-state timeout.
module cpu_lsu #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                req_ready,
    output logic                busy,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ready,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(BE_W);
    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [DATA_W-1:0] ONES = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef struct packed {
        logic             we;
        logic [1:0]       size;
        logic             uns;
        logic [OFF_W-1:0] off;
    } req_t;

    state_t              state, state_d;
    logic [CNT_W-1:0]    cnt, cnt_d, cnt_inc_c;
    req_t                lat, lat_d;

    logic                req_ready_d, busy_d, rsp_valid_d, rsp_err_d;
    logic [DATA_W-1:0]   rsp_rdata_d;
    logic                mem_en_d, mem_we_d;
    logic [BE_W-1:0]     mem_be_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_d;

    logic [OFF_W-1:0]    req_off_c;
    logic                illegal_c;
    logic                timeout_c;
    logic [BE_W-1:0]     be_c;
    logic [DATA_W-1:0]   wdata_c;
    logic [DATA_W-1:0]   shifted_c;
    logic [DATA_W-1:0]   hi_mask_c;
    logic                sign_c;
    logic [DATA_W-1:0]   load_c;

    assign req_off_c = req_addr[OFF_W-1:0];
    assign cnt_inc_c = cnt + CNT_W'(1);
    assign timeout_c = (TIMEOUT != 0) && (cnt_inc_c == CNT_W'(TIMEOUT));

    // Alignment / legality of the incoming request
    always_comb begin
        illegal_c = 1'b0;
        case (req_size)
            2'b00:   illegal_c = 1'b0;
            2'b01:   illegal_c = req_addr[0];
            2'b10:   illegal_c = |req_addr[1:0];
            default: illegal_c = (DATA_W != 64) || (|req_addr[2:0]);
        endcase
    end

    // Byte enables and lane-replicated store data
    always_comb begin
        be_c = '0;
        case (req_size)
            2'b00:   be_c = BE_W'(1) << req_off_c;
            2'b01:   be_c = BE_W'(2'b11) << req_off_c;
            2'b10:   be_c = BE_W'(4'hF) << req_off_c;
            default: be_c = '1;
        endcase
    end

    always_comb begin
        wdata_c = req_wdata;
        for (int i = 0; i < int'(BE_W); i++) begin
            case (req_size)
                2'b00:   wdata_c[i*8 +: 8] = req_wdata[7:0];
                2'b01:   wdata_c[i*8 +: 8] = req_wdata[(i % 2)*8 +: 8];
                2'b10:   wdata_c[i*8 +: 8] = req_wdata[(i % 4)*8 +: 8];
                default: wdata_c[i*8 +: 8] = req_wdata[i*8 +: 8];
            endcase
        end
    end

    // Load lane select and sign/zero extension from the latched request
    always_comb begin
        shifted_c = mem_rdata >> {lat.off, 3'b000};
        hi_mask_c = '0;
        sign_c    = 1'b0;
        case (lat.size)
            2'b00: begin
                hi_mask_c = ONES << 8;
                sign_c    = shifted_c[7];
            end
            2'b01: begin
                hi_mask_c = ONES << 16;
                sign_c    = shifted_c[15];
            end
            2'b10: begin
                hi_mask_c = ONES << 32;
                sign_c    = shifted_c[31];
            end
            default: begin
                hi_mask_c = '0;
                sign_c    = 1'b0;
            end
        endcase
        load_c = (sign_c && !lat.uns) ? (shifted_c | hi_mask_c) : (shifted_c & ~hi_mask_c);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            lat       <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            lat       <= lat_d;
            req_ready <= req_ready_d;
            busy      <= busy_d;
            rsp_valid <= rsp_valid_d;
            rsp_err   <= rsp_err_d;
            rsp_rdata <= rsp_rdata_d;
            mem_en    <= mem_en_d;
            mem_we    <= mem_we_d;
            mem_be    <= mem_be_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
        end
    end

    // Next state plus the registered value of every output
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        lat_d       = lat;
        req_ready_d = 1'b0;
        busy_d      = 1'b1;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_be_d    = '0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    lat_d = {req_we, req_size, req_unsigned, req_off_c};
                    cnt_d = '0;
                    if (illegal_c) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d     = ACCESS;
                        mem_en_d    = 1'b1;
                        mem_we_d    = req_we;
                        mem_be_d    = be_c;
                        mem_addr_d  = {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                        mem_wdata_d = wdata_c;
                    end
                end else begin
                    req_ready_d = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            ACCESS: begin
                cnt_d = cnt_inc_c;
                if (mem_ready) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = lat.we ? '0 : load_c;
                end else if (timeout_c) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    mem_en_d = 1'b1;
                    mem_we_d = mem_we;
                    mem_be_d = mem_be;
                end
            end
            RESP: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                busy_d      = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_lsu.sv
// Scoreboard bench for cpu_lsu: a 32-bit instance (TIMEOUT=4) and a 64-bit instance.
module tb_cpu_lsu;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req32_valid, req32_we, req32_uns;
    logic [1:0]  req32_size;
    logic [31:0] req32_addr, req32_wdata;
    logic        ready32, busy32, rv32, err32, en32, we32, mrdy32;
    logic [31:0] rdata32, maddr32, mwdata32, mrdata32;
    logic [3:0]  be32;

    logic        req64_valid, req64_we, req64_uns;
    logic [1:0]  req64_size;
    logic [31:0] req64_addr, maddr64;
    logic [63:0] req64_wdata, rdata64, mwdata64, mrdata64;
    logic        ready64, busy64, rv64, err64, en64, we64, mrdy64;
    logic [7:0]  be64;

    cpu_lsu #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) u_lsu32 (
        .clk(clk), .rst(rst),
        .req_valid(req32_valid), .req_we(req32_we), .req_size(req32_size),
        .req_unsigned(req32_uns), .req_addr(req32_addr), .req_wdata(req32_wdata),
        .req_ready(ready32), .busy(busy32),
        .rsp_valid(rv32), .rsp_rdata(rdata32), .rsp_err(err32),
        .mem_en(en32), .mem_we(we32), .mem_be(be32), .mem_addr(maddr32),
        .mem_wdata(mwdata32), .mem_ready(mrdy32), .mem_rdata(mrdata32)
    );

    cpu_lsu #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(4)) u_lsu64 (
        .clk(clk), .rst(rst),
        .req_valid(req64_valid), .req_we(req64_we), .req_size(req64_size),
        .req_unsigned(req64_uns), .req_addr(req64_addr), .req_wdata(req64_wdata),
        .req_ready(ready64), .busy(busy64),
        .rsp_valid(rv64), .rsp_rdata(rdata64), .rsp_err(err64),
        .mem_en(en64), .mem_we(we64), .mem_be(be64), .mem_addr(maddr64),
        .mem_wdata(mwdata64), .mem_ready(mrdy64), .mem_rdata(mrdata64)
    );

    typedef struct {
        logic        err;
        logic [63:0] rdata;
        int          due;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   wait32 = 0, wait64 = 0;
    int   acc32 = 0, acc64 = 0;
    int   en_cnt32 = 0, busy_cnt32 = 0, en_cnt64 = 0;

    always @(posedge clk) cyc++;

    // Memory models: assert mem_ready on access cycle wait+1
    always @(posedge clk) begin
        #1;
        if (en32) acc32++; else acc32 = 0;
        mrdy32 = en32 && (acc32 == wait32 + 1);
        if (en64) acc64++; else acc64 = 0;
        mrdy64 = en64 && (acc64 == wait64 + 1);
    end

    // Response monitors: pop the scoreboard on every rsp_valid
    always @(negedge clk) begin
        exp_t e;
        if (en32) en_cnt32++;
        if (busy32) busy_cnt32++;
        if (!en32) begin
            checks++;
            if (we32 !== 1'b0 || be32 !== 4'h0) begin
                errors++;
                $display("FAIL idle_strobes32: we=%b be=%h required 0/0", we32, be32);
            end
        end
        if (rv32 === 1'b1) begin
            checks++;
            if (q32.size() == 0) begin
                errors++;
                $display("FAIL rsp32_unexpected: rsp_valid at cycle %0d with nothing pending", cyc);
            end else begin
                e = q32.pop_front();
                if (err32 !== e.err || rdata32 !== e.rdata[31:0] || cyc != e.due) begin
                    errors++;
                    $display("FAIL rsp32: err=%b rdata=%h cycle=%0d required err=%b rdata=%h cycle=%0d",
                             err32, rdata32, cyc, e.err, e.rdata[31:0], e.due);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (en64) en_cnt64++;
        if (rv64 === 1'b1) begin
            checks++;
            if (q64.size() == 0) begin
                errors++;
                $display("FAIL rsp64_unexpected: rsp_valid at cycle %0d with nothing pending", cyc);
            end else begin
                e = q64.pop_front();
                if (err64 !== e.err || rdata64 !== e.rdata || cyc != e.due) begin
                    errors++;
                    $display("FAIL rsp64: err=%b rdata=%h cycle=%0d required err=%b rdata=%h cycle=%0d",
                             err64, rdata64, cyc, e.err, e.rdata, e.due);
                end
            end
        end
    end

    // k = edges from acceptance to the rsp_valid cycle (spec latency minus one)
    task automatic issue32(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic exp_err, input logic [31:0] exp_rdata,
                           input int k, output int acc_cyc);
        exp_t e;
        int   guard = 0;
        @(posedge clk); #1;
        while (ready32 !== 1'b1 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (ready32 !== 1'b1) begin
            errors++;
            $display("FAIL issue32_ready: req_ready=%b required 1", ready32);
        end
        req32_valid = 1'b1; req32_we = we; req32_size = size; req32_uns = uns;
        req32_addr = addr; req32_wdata = wdata;
        acc_cyc = cyc + 1;
        e.err = exp_err; e.rdata = {32'h0, exp_rdata}; e.due = acc_cyc + k;
        q32.push_back(e);
        @(posedge clk); #1;
        req32_valid = 1'b0;
    endtask

    task automatic issue64(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [63:0] wdata,
                           input logic exp_err, input logic [63:0] exp_rdata,
                           input int k, output int acc_cyc);
        exp_t e;
        int   guard = 0;
        @(posedge clk); #1;
        while (ready64 !== 1'b1 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (ready64 !== 1'b1) begin
            errors++;
            $display("FAIL issue64_ready: req_ready=%b required 1", ready64);
        end
        req64_valid = 1'b1; req64_we = we; req64_size = size; req64_uns = uns;
        req64_addr = addr; req64_wdata = wdata;
        acc_cyc = cyc + 1;
        e.err = exp_err; e.rdata = exp_rdata; e.due = acc_cyc + k;
        q64.push_back(e);
        @(posedge clk); #1;
        req64_valid = 1'b0;
    endtask

    task automatic drain32();
        int n = 0;
        @(negedge clk);
        while ((q32.size() != 0 || busy32 !== 1'b0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q32.size() != 0 || busy32 !== 1'b0) begin
            errors++;
            $display("FAIL drain32: pending=%0d busy=%b required 0/0", q32.size(), busy32);
        end
    endtask

    task automatic drain64();
        int n = 0;
        @(negedge clk);
        while ((q64.size() != 0 || busy64 !== 1'b0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q64.size() != 0 || busy64 !== 1'b0) begin
            errors++;
            $display("FAIL drain64: pending=%0d busy=%b required 0/0", q64.size(), busy64);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req32_valid = 0; req32_we = 0; req32_size = 0; req32_uns = 0; req32_addr = 0; req32_wdata = 0;
        req64_valid = 0; req64_we = 0; req64_size = 0; req64_uns = 0; req64_addr = 0; req64_wdata = 0;
        mrdy32 = 0; mrdata32 = 0; mrdy64 = 0; mrdata64 = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({ready32, busy32, rv32, err32, en32} !== 5'b10000) begin
            errors++;
            $display("FAIL reset32_ctrl: ready,busy,rv,err,en=%b required 10000",
                     {ready32, busy32, rv32, err32, en32});
        end
        checks++;
        if (rdata32 !== 32'h0 || maddr32 !== 32'h0 || mwdata32 !== 32'h0 || be32 !== 4'h0) begin
            errors++;
            $display("FAIL reset32_data: rdata=%h addr=%h wdata=%h be=%h required all 0",
                     rdata32, maddr32, mwdata32, be32);
        end
        checks++;
        if ({ready64, busy64, rv64, en64} !== 4'b1000 || be64 !== 8'h0 || rdata64 !== 64'h0) begin
            errors++;
            $display("FAIL reset64: ready,busy,rv,en=%b be=%h rdata=%h required 1000/00/0",
                     {ready64, busy64, rv64, en64}, be64, rdata64);
        end
        rst = 1'b1;
    endtask

    task automatic test_word_store();
        int a;
        wait32 = 0;
        issue32(1'b1, 2'b10, 1'b0, 32'h104, 32'hDEADBEEF, 1'b0, 32'h0, 1, a);
        @(negedge clk);
        checks++;
        if ({en32, we32, be32} !== 6'b111111 || maddr32 !== 32'h104 || mwdata32 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL word_store_mem: en,we,be=%b addr=%h wdata=%h required 111111/104/deadbeef",
                     {en32, we32, be32}, maddr32, mwdata32);
        end
        drain32();
    endtask

    task automatic test_byte_load();
        int a;
        logic [31:0] exp;
        for (int u = 0; u < 2; u++) begin
            wait32 = 3; mrdata32 = 32'h80FF_0000; en_cnt32 = 0;
            exp = (u == 1) ? 32'h0000_0080 : 32'hFFFF_FF80;
            issue32(1'b0, 2'b00, u[0], 32'h203, 32'h0, 1'b0, exp, 4, a);
            @(negedge clk);
            checks++;
            if (be32 !== 4'h8 || maddr32 !== 32'h200 || we32 !== 1'b0) begin
                errors++;
                $display("FAIL byte_load_mem: be=%h addr=%h we=%b required 8/200/0", be32, maddr32, we32);
            end
            drain32();
            checks++;
            if (en_cnt32 != 4) begin
                errors++;
                $display("FAIL byte_load_en_cycles: got %0d required 4", en_cnt32);
            end
            repeat (2) @(negedge clk);
            checks++;
            if (rdata32 !== exp) begin
                errors++;
                $display("FAIL rdata_hold: got %h required %h", rdata32, exp);
            end
        end
    endtask

    task automatic test_half_store();
        int a;
        wait32 = 1;
        issue32(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_ABCD, 1'b0, 32'h0, 2, a);
        @(negedge clk);
        checks++;
        if (be32 !== 4'hC || mwdata32 !== 32'hABCD_ABCD || maddr32 !== 32'h10) begin
            errors++;
            $display("FAIL half_store_mem: be=%h wdata=%h addr=%h required c/abcdabcd/10",
                     be32, mwdata32, maddr32);
        end
        drain32();
    endtask

    task automatic test_misaligned();
        logic [1:0]  sizes [3] = '{2'b10, 2'b01, 2'b11};
        logic [31:0] addrs [3] = '{32'h101, 32'h103, 32'h0};
        int a;
        for (int i = 0; i < 3; i++) begin
            en_cnt32 = 0; busy_cnt32 = 0;
            issue32(1'b0, sizes[i], 1'b0, addrs[i], 32'h0, 1'b1, 32'h0, 0, a);
            @(negedge clk);
            checks++;
            if (en32 !== 1'b0 || busy32 !== 1'b1) begin
                errors++;
                $display("FAIL misaligned_state[%0d]: en=%b busy=%b required 0/1", i, en32, busy32);
            end
            drain32();
            checks++;
            if (en_cnt32 != 0 || busy_cnt32 != 1) begin
                errors++;
                $display("FAIL misaligned_cycles[%0d]: en_cycles=%0d busy_cycles=%0d required 0/1",
                         i, en_cnt32, busy_cnt32);
            end
        end
    endtask

    task automatic test_timeout();
        int a;
        wait32 = 100; en_cnt32 = 0;
        issue32(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 1'b1, 32'h0, 4, a);
        drain32();
        checks++;
        if (en_cnt32 != 4) begin
            errors++;
            $display("FAIL timeout_en_cycles: got %0d required 4", en_cnt32);
        end
        wait32 = 3; en_cnt32 = 0; mrdata32 = 32'h1357_2468;
        issue32(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 1'b0, 32'h1357_2468, 4, a);
        drain32();
        checks++;
        if (en_cnt32 != 4) begin
            errors++;
            $display("FAIL ready_at_limit_en_cycles: got %0d required 4", en_cnt32);
        end
    endtask

    task automatic test_back_to_back();
        int a1, a2, a3;
        wait32 = 0; mrdata32 = 32'h8001_1234;
        issue32(1'b0, 2'b01, 1'b0, 32'h42, 32'h0, 1'b0, 32'hFFFF_8001, 1, a1);
        issue32(1'b0, 2'b10, 1'b1, 32'h40, 32'h0, 1'b0, 32'h8001_1234, 1, a2);
        issue32(1'b0, 2'b01, 1'b1, 32'h42, 32'h0, 1'b0, 32'h0000_8001, 1, a3);
        checks++;
        if (a2 - a1 != 3 || a3 - a2 != 3) begin
            errors++;
            $display("FAIL back_to_back_spacing: got %0d,%0d required 3,3", a2 - a1, a3 - a2);
        end
        drain32();
    endtask

    task automatic test_reset_mid_access();
        int a;
        wait32 = 100;
        issue32(1'b0, 2'b10, 1'b0, 32'h500, 32'h0, 1'b0, 32'h0, 4, a);
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        q32.delete();
        checks++;
        if ({en32, busy32, ready32, rv32} !== 4'b0010) begin
            errors++;
            $display("FAIL reset_mid_access: en,busy,ready,rv=%b required 0010",
                     {en32, busy32, ready32, rv32});
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (busy32 !== 1'b0 || ready32 !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_after: busy=%b ready=%b required 0/1", busy32, ready32);
        end
    endtask

    task automatic test_double();
        int a;
        wait64 = 0; mrdata64 = 64'h0123_4567_89AB_CDEF;
        issue64(1'b0, 2'b11, 1'b0, 32'h8, 64'h0, 1'b0, 64'h0123_4567_89AB_CDEF, 1, a);
        @(negedge clk);
        checks++;
        if (be64 !== 8'hFF || maddr64 !== 32'h8 || en64 !== 1'b1) begin
            errors++;
            $display("FAIL double_mem: be=%h addr=%h en=%b required ff/8/1", be64, maddr64, en64);
        end
        drain64();
        en_cnt64 = 0;
        issue64(1'b0, 2'b11, 1'b0, 32'h4, 64'h0, 1'b1, 64'h0, 0, a);
        drain64();
        checks++;
        if (en_cnt64 != 0) begin
            errors++;
            $display("FAIL double_misaligned_en: got %0d cycles required 0", en_cnt64);
        end
        issue64(1'b0, 2'b10, 1'b0, 32'h4, 64'h0, 1'b0, 64'h0000_0000_0123_4567, 1, a);
        @(negedge clk);
        checks++;
        if (be64 !== 8'hF0 || maddr64 !== 32'h0) begin
            errors++;
            $display("FAIL word64_mem: be=%h addr=%h required f0/0", be64, maddr64);
        end
        drain64();
        issue64(1'b0, 2'b00, 1'b0, 32'h0, 64'h0, 1'b0, 64'hFFFF_FFFF_FFFF_FFEF, 1, a);
        issue64(1'b1, 2'b00, 1'b0, 32'h5, 64'h5A, 1'b0, 64'h0, 1, a);
        @(negedge clk);
        checks++;
        if (be64 !== 8'h20 || mwdata64 !== 64'h5A5A_5A5A_5A5A_5A5A || we64 !== 1'b1) begin
            errors++;
            $display("FAIL byte_store64_mem: be=%h wdata=%h we=%b required 20/5a5a5a5a5a5a5a5a/1",
                     be64, mwdata64, we64);
        end
        drain64();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_word_store();
        test_byte_load();
        test_half_store();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_reset_mid_access();
        test_double();
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
